// File: rtl/kf8259_common_package.sv
// Shared types and helpers for the 8259 interrupt-acknowledge path.
// priority_rotate names the lowest-priority level, so IR(priority_rotate+1) is the highest.
package kf8259_common_package;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } ack_state_t;

  localparam logic [2:0] CMD_AEOI_ROT_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI       = 3'b001;
  localparam logic [2:0] CMD_NOP          = 3'b010;
  localparam logic [2:0] CMD_S_EOI        = 3'b011;
  localparam logic [2:0] CMD_AEOI_ROT_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] CMD_SET_PRIORITY = 3'b110;
  localparam logic [2:0] CMD_ROT_S_EOI    = 3'b111;

  // Rotating by lowest+1 brings the highest-priority level down to bit 0.
  function automatic logic [7:0] rotate_right(input logic [7:0] source, input logic [2:0] lowest);
    logic [15:0] doubled;
    logic [3:0]  amount;
    amount  = {1'b0, lowest} + 4'd1;
    doubled = {source, source} >> amount;
    return doubled[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] source, input logic [2:0] lowest);
    logic [15:0] doubled;
    logic [3:0]  amount;
    amount  = {1'b0, lowest} + 4'd1;
    doubled = {source, source} << amount;
    return doubled[15:8];
  endfunction

  function automatic logic [7:0] resolv_priority(input logic [7:0] request, input logic [2:0] lowest);
    logic [7:0] rotated;
    logic [7:0] lowest_bit;
    rotated    = rotate_right(request, lowest);
    lowest_bit = rotated & (~rotated + 8'd1);
    return rotate_left(lowest_bit, lowest);
  endfunction

  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] index;
    index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) begin
        index = 3'(i);
      end
    end
    return index;
  endfunction

endpackage

// File: rtl/kf8259_priority_compare.sv
// Picks the winning request under the current rotation and compares it
// against the highest level already in service.
module kf8259_priority_compare
  import kf8259_common_package::*;
(
  input  logic [7:0] interrupt_request,
  input  logic [7:0] in_service_register,
  input  logic [7:0] highest_level_in_service,
  input  logic [2:0] priority_rotate,
  output logic [7:0] resolved_request,
  output logic       request_higher_than_isr
);

  logic [7:0] rotated_request;
  logic [7:0] rotated_highest;

  // After rotation a smaller one-hot value means a higher priority.
  always_comb begin
    resolved_request = resolv_priority(interrupt_request, priority_rotate);
    rotated_request  = rotate_right(resolved_request, priority_rotate);
    rotated_highest  = rotate_right(highest_level_in_service, priority_rotate);
    if (in_service_register == 8'h00) begin
      request_higher_than_isr = 1'b1;
    end else begin
      request_higher_than_isr = (rotated_request < rotated_highest);
    end
  end

endmodule

// File: rtl/kf8259_interrupt_ack_sequencer.sv
// 8259 in-service sequencer: two-pulse INTA handshake, vector drive,
// OCW2 end-of-interrupt / rotation decode and auto-EOI.
module kf8259_interrupt_ack_sequencer
  import kf8259_common_package::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] interrupt_request,
  input  logic [7:0] in_service_register,
  input  logic [7:0] highest_level_in_service,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic [4:0] icw2_vector,
  input  logic       auto_eoi_config,
  output logic       interrupt,
  output logic       latch_in_service,
  output logic [7:0] interrupt_to_service,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] vector_out,
  output logic       vector_out_enable
);

  ack_state_t state;
  logic       inta_prev;
  logic       rotate_in_aeoi;
  logic       spurious;
  logic       inta_fall;
  logic       inta_rise;
  logic       aeoi_fire;
  logic [7:0] resolved_request;
  logic       request_higher_than_isr;
  logic [7:0] ocw2_eoi;
  logic       ocw2_rotate_valid;
  logic [2:0] ocw2_rotate_value;
  logic       ocw2_unused_bits;

  kf8259_priority_compare u_priority_compare (
    .interrupt_request        (interrupt_request),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .resolved_request         (resolved_request),
    .request_higher_than_isr  (request_higher_than_isr)
  );

  assign inta_fall        = inta_prev & ~interrupt_acknowledge_n;
  assign inta_rise        = ~inta_prev & interrupt_acknowledge_n;
  assign aeoi_fire        = (state == ACK2) & inta_rise & auto_eoi_config & ~spurious;
  assign ocw2_unused_bits = ^ocw2_data[4:3];

  // OCW2 command decode into EOI clear mask and rotation update.
  always_comb begin
    ocw2_eoi          = 8'h00;
    ocw2_rotate_valid = 1'b0;
    ocw2_rotate_value = 3'd0;
    if (ocw2_write) begin
      case (ocw2_data[7:5])
        CMD_NS_EOI: begin
          ocw2_eoi = highest_level_in_service;
        end
        CMD_S_EOI: begin
          ocw2_eoi = 8'h01 << ocw2_data[2:0];
        end
        CMD_ROT_NS_EOI: begin
          ocw2_eoi          = highest_level_in_service;
          ocw2_rotate_valid = |highest_level_in_service;
          ocw2_rotate_value = onehot_to_index(highest_level_in_service);
        end
        CMD_ROT_S_EOI: begin
          ocw2_eoi          = 8'h01 << ocw2_data[2:0];
          ocw2_rotate_valid = 1'b1;
          ocw2_rotate_value = ocw2_data[2:0];
        end
        CMD_SET_PRIORITY: begin
          ocw2_rotate_valid = 1'b1;
          ocw2_rotate_value = ocw2_data[2:0];
        end
        default: begin
          ocw2_eoi = 8'h00;
        end
      endcase
    end else begin
      ocw2_eoi = 8'h00;
    end
  end

  // Acknowledge FSM with registered outputs; OCW2 rotation outranks AEOI rotation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      inta_prev            <= 1'b1;
      rotate_in_aeoi       <= 1'b0;
      spurious             <= 1'b0;
      interrupt            <= 1'b0;
      latch_in_service     <= 1'b0;
      interrupt_to_service <= 8'h00;
      end_of_interrupt     <= 8'h00;
      priority_rotate      <= 3'b111;
      vector_out           <= 8'h00;
      vector_out_enable    <= 1'b0;
    end else begin
      inta_prev        <= interrupt_acknowledge_n;
      latch_in_service <= 1'b0;
      end_of_interrupt <= ocw2_eoi | (aeoi_fire ? interrupt_to_service : 8'h00);

      if (ocw2_rotate_valid) begin
        priority_rotate <= ocw2_rotate_value;
      end else if (aeoi_fire && rotate_in_aeoi) begin
        priority_rotate <= onehot_to_index(interrupt_to_service);
      end

      if (ocw2_write && (ocw2_data[7:5] == CMD_AEOI_ROT_SET)) begin
        rotate_in_aeoi <= 1'b1;
      end else if (ocw2_write && (ocw2_data[7:5] == CMD_AEOI_ROT_CLR)) begin
        rotate_in_aeoi <= 1'b0;
      end

      case (state)
        IDLE: begin
          interrupt <= (|resolved_request) & request_higher_than_isr;
          if (inta_fall) begin
            interrupt <= 1'b0;
            state     <= ACK1;
            if (|resolved_request) begin
              interrupt_to_service <= resolved_request;
              latch_in_service     <= 1'b1;
              spurious             <= 1'b0;
            end else begin
              interrupt_to_service <= 8'h80;
              spurious             <= 1'b1;
            end
          end
        end
        ACK1: begin
          interrupt <= 1'b0;
          if (inta_rise) begin
            state <= WAIT2;
          end
        end
        WAIT2: begin
          interrupt <= 1'b0;
          if (inta_fall) begin
            state             <= ACK2;
            vector_out        <= {icw2_vector, onehot_to_index(interrupt_to_service)};
            vector_out_enable <= 1'b1;
          end
        end
        ACK2: begin
          interrupt <= 1'b0;
          if (inta_rise) begin
            state                <= IDLE;
            vector_out           <= 8'h00;
            vector_out_enable    <= 1'b0;
            interrupt_to_service <= 8'h00;
            spurious             <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf8259_interrupt_ack_sequencer.sv
// Directed and randomized bench for the 8259 acknowledge sequencer, checked
// against a rank-based priority model; the bench also plays the ISR register.
module tb_kf8259_interrupt_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       interrupt_acknowledge_n;
  logic [7:0] interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic       ocw2_write;
  logic [7:0] ocw2_data;
  logic [4:0] icw2_vector;
  logic       auto_eoi_config;
  logic       interrupt;
  logic       latch_in_service;
  logic [7:0] interrupt_to_service;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] vector_out;
  logic       vector_out_enable;

  int         n_checks = 0;
  int         n_fail = 0;
  int         m_rot = 7;
  bit         m_rot_aeoi = 1'b0;
  logic [7:0] isr = 8'h00;

  always #5 clock = ~clock;

  kf8259_interrupt_ack_sequencer dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt_acknowledge_n  (interrupt_acknowledge_n),
    .interrupt_request        (interrupt_request),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .ocw2_write               (ocw2_write),
    .ocw2_data                (ocw2_data),
    .icw2_vector              (icw2_vector),
    .auto_eoi_config          (auto_eoi_config),
    .interrupt                (interrupt),
    .latch_in_service         (latch_in_service),
    .interrupt_to_service     (interrupt_to_service),
    .end_of_interrupt         (end_of_interrupt),
    .priority_rotate          (priority_rotate),
    .vector_out               (vector_out),
    .vector_out_enable        (vector_out_enable)
  );

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Rank 0 is the highest priority: the level just after the lowest one.
  function automatic int rank_of(input int level, input int rot);
    return (level - rot + 15) % 8;
  endfunction

  function automatic int winner(input logic [7:0] v, input int rot);
    int best = -1;
    for (int l = 0; l < 8; l++) begin
      if (v[l] && (best < 0 || rank_of(l, rot) < rank_of(best, rot))) best = l;
    end
    return best;
  endfunction

  function automatic logic [7:0] level_mask(input int l);
    logic [7:0] one = 8'h01;
    return (l < 0) ? 8'h00 : (one << l);
  endfunction

  function automatic bit model_int();
    int w = winner(interrupt_request, m_rot);
    if (w < 0) return 1'b0;
    if (isr == 8'h00) return 1'b1;
    return rank_of(w, m_rot) < rank_of(winner(isr, m_rot), m_rot);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    in_service_register      = isr;
    highest_level_in_service = level_mask(winner(isr, m_rot));
  endtask

  task automatic settle(input string tag);
    tick();
    tick();
    check_value(tag, interrupt, model_int());
  endtask

  task automatic write_ocw2(input logic [7:0] data);
    logic [2:0] cmd     = data[7:5];
    int         l       = int'(data[2:0]);
    int         h       = winner(isr, m_rot);
    logic [7:0] exp_eoi = 8'h00;
    case (cmd)
      3'b001: exp_eoi = level_mask(h);
      3'b011: exp_eoi = level_mask(l);
      3'b101: begin exp_eoi = level_mask(h); if (h >= 0) m_rot = h; end
      3'b111: begin exp_eoi = level_mask(l); m_rot = l; end
      3'b110: m_rot = l;
      3'b100: m_rot_aeoi = 1'b1;
      3'b000: m_rot_aeoi = 1'b0;
      default: ;
    endcase
    ocw2_write = 1'b1;
    ocw2_data  = data;
    tick();
    ocw2_write = 1'b0;
    check_value("ocw2 eoi", end_of_interrupt, exp_eoi);
    check_value("ocw2 rotate", priority_rotate, m_rot);
    isr = isr & ~exp_eoi;
    tick();
    check_value("ocw2 eoi end", end_of_interrupt, 8'h00);
  endtask

  task automatic run_inta(input string tag);
    int         w   = winner(interrupt_request, m_rot);
    logic [7:0] its = (w < 0) ? 8'h80 : level_mask(w);
    logic [2:0] idx = (w < 0) ? 3'd7 : 3'(w);
    bit         aeoi;
    interrupt_acknowledge_n = 1'b0;
    tick();
    check_value({tag, " latch"}, latch_in_service, (w >= 0));
    check_value({tag, " its"}, interrupt_to_service, its);
    check_value({tag, " int ack1"}, interrupt, 1'b0);
    if (w >= 0) isr = isr | its;
    tick();
    check_value({tag, " latch end"}, latch_in_service, 1'b0);
    interrupt_acknowledge_n = 1'b1;
    tick();
    tick();
    check_value({tag, " int wait2"}, interrupt, 1'b0);
    interrupt_acknowledge_n = 1'b0;
    tick();
    check_value({tag, " vec en"}, vector_out_enable, 1'b1);
    check_value({tag, " vector"}, vector_out, {icw2_vector, idx});
    tick();
    check_value({tag, " vec hold"}, vector_out_enable, 1'b1);
    check_value({tag, " int ack2"}, interrupt, 1'b0);
    aeoi = auto_eoi_config && (w >= 0);
    if (aeoi && m_rot_aeoi) m_rot = w;
    interrupt_acknowledge_n = 1'b1;
    tick();
    check_value({tag, " aeoi"}, end_of_interrupt, aeoi ? its : 8'h00);
    check_value({tag, " vec off"}, vector_out_enable, 1'b0);
    check_value({tag, " rotate"}, priority_rotate, m_rot);
    check_value({tag, " its clr"}, interrupt_to_service, 8'h00);
    if (aeoi) isr = isr & ~its;
    tick();
    check_value({tag, " aeoi end"}, end_of_interrupt, 8'h00);
  endtask

  initial begin
    reset                   = 1'b1;
    interrupt_acknowledge_n = 1'b1;
    interrupt_request       = 8'h00;
    in_service_register     = 8'h00;
    highest_level_in_service = 8'h00;
    ocw2_write              = 1'b0;
    ocw2_data               = 8'h00;
    icw2_vector             = 5'h00;
    auto_eoi_config         = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_value("rst interrupt", interrupt, 1'b0);
    check_value("rst latch", latch_in_service, 1'b0);
    check_value("rst its", interrupt_to_service, 8'h00);
    check_value("rst eoi", end_of_interrupt, 8'h00);
    check_value("rst rotate", priority_rotate, 3'b111);
    check_value("rst vector", vector_out, 8'h00);
    check_value("rst vec en", vector_out_enable, 1'b0);

    // Basic acknowledge of IRQ3.
    icw2_vector       = 5'h01;
    interrupt_request = 8'h08;
    settle("irq3 int");
    check_value("irq3 int high", interrupt, 1'b1);
    run_inta("irq3");
    write_ocw2(8'h20);
    interrupt_request = 8'h00;
    settle("idle int");

    // Auto-EOI with rotation.
    auto_eoi_config = 1'b1;
    write_ocw2(8'h80);
    interrupt_request = 8'h20;
    settle("irq5 int");
    run_inta("irq5 aeoi");
    check_value("aeoi rot5", priority_rotate, 3'd5);
    interrupt_request = 8'h60;
    settle("irq56 int");
    run_inta("irq6 wins");
    write_ocw2(8'h00);
    auto_eoi_config   = 1'b0;
    interrupt_request = 8'h00;
    write_ocw2(8'hC7);

    // OCW2 EOI forms.
    isr = 8'h04;
    tick();
    write_ocw2(8'h20);
    write_ocw2(8'hE6);
    write_ocw2(8'hC7);

    // Spurious acknowledge, even with AEOI enabled.
    interrupt_request = 8'h10;
    settle("spur int");
    interrupt_request = 8'h00;
    auto_eoi_config   = 1'b1;
    run_inta("spurious");
    auto_eoi_config = 1'b0;

    // Request blocked by a higher level in service.
    isr               = 8'h02;
    interrupt_request = 8'h10;
    settle("blocked int");
    write_ocw2(8'hC0);
    settle("blocked rot0");
    write_ocw2(8'h61);
    settle("unblocked int");
    check_value("unblocked high", interrupt, 1'b1);
    interrupt_request = 8'h00;

    // Reset in the middle of a handshake.
    write_ocw2(8'hC3);
    interrupt_request       = 8'h04;
    interrupt_acknowledge_n = 1'b0;
    tick();
    tick();
    interrupt_acknowledge_n = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    m_rot = 7;
    m_rot_aeoi = 1'b0;
    isr = 8'h00;
    tick();
    reset = 1'b0;
    check_value("midrst vec en", vector_out_enable, 1'b0);
    check_value("midrst rotate", priority_rotate, 3'd7);
    check_value("midrst eoi", end_of_interrupt, 8'h00);
    check_value("midrst its", interrupt_to_service, 8'h00);
    tick();
    check_value("midrst eoi2", end_of_interrupt, 8'h00);
    check_value("midrst latch", latch_in_service, 1'b0);
    interrupt_request = 8'h00;

    // Randomized mix of requests, OCW2 commands and acknowledges.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          interrupt_request = 8'($urandom);
          settle("rand int");
        end
        1: begin
          logic [2:0] cmd = 3'($urandom);
          logic [2:0] lvl = 3'($urandom);
          write_ocw2({cmd, 2'b00, lvl});
        end
        default: begin
          interrupt_request = 8'($urandom);
          icw2_vector       = 5'($urandom);
          auto_eoi_config   = 1'($urandom);
          settle("rand pre int");
          run_inta("rand inta");
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
